// File: rtl/pipeline_mem_stage_if.sv
// -----------------------------------------------------------------------------
// pipeline_mem_stage_if
// Valid/ready bus carrying one EX->MEM pipeline entry.
//   valid       : producer presents an entry
//   ready       : consumer accepts the entry this cycle
//   reg_write   : RegWrite control
//   result_src  : ResultSrc select (RS_W bits)
//   mem_write   : MemWrite control
//   alu_result  : ALU result (XLEN bits)
//   write_data  : store data (XLEN bits)
//   rd          : destination register index (RD_W bits)
//   pc_plus4    : PC+4 (XLEN bits)
// Modports: master drives valid + payload, slave drives ready.
// -----------------------------------------------------------------------------
interface pipeline_mem_stage_if #(
    parameter int XLEN = 32,
    parameter int RS_W = 2,
    parameter int RD_W = 5
);
    logic            valid;
    logic            ready;
    logic            reg_write;
    logic [RS_W-1:0] result_src;
    logic            mem_write;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] pc_plus4;

    modport master (
        output valid, reg_write, result_src, mem_write,
               alu_result, write_data, rd, pc_plus4,
        input  ready
    );

    modport slave (
        input  valid, reg_write, result_src, mem_write,
               alu_result, write_data, rd, pc_plus4,
        output ready
    );
endinterface

// File: rtl/pipeline_mem_stage.sv
// -----------------------------------------------------------------------------
// pipeline_mem_stage
// EX->MEM pipeline register with valid/ready handshake and a two-entry
// (main + skid) buffer so EX never sees a combinational path from MEM ready.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_flush      : synchronous kill of held and incoming entries
//   ex_if        : slave side of the EX bus (i_valid/o_ready + EX payload)
//   mem_if       : master side of the MEM bus (o_valid/i_ready + MEM payload,
//                  reg_write/mem_write gated by valid)
//   o_fwd_en     : forwarding tap valid (valid & gated reg_write)
//   o_stall_cnt  : cycles with valid & ~ready (optional)
//   o_bubble_cnt : cycles with ~valid (optional)
// Build option: define PIPE_STAGE_PERF_CNT_EN to include the saturating
// performance counters; otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module pipeline_mem_stage #(
    parameter int XLEN  = 32,
    parameter int RS_W  = 2,
    parameter int RD_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    pipeline_mem_stage_if.slave  ex_if,
    pipeline_mem_stage_if.master mem_if,
    output logic                 o_fwd_en,
    output logic [CNT_W-1:0]     o_stall_cnt,
    output logic [CNT_W-1:0]     o_bubble_cnt
);

    typedef struct packed {
        logic            reg_write;
        logic [RS_W-1:0] result_src;
        logic            mem_write;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] pc_plus4;
    } entry_t;

    entry_t m_q, m_d, s_q, s_d, in_ent;
    logic   m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic   acc, take, rw_gated;

    assign in_ent = '{reg_write:  ex_if.reg_write,
                      result_src: ex_if.result_src,
                      mem_write:  ex_if.mem_write,
                      alu_result: ex_if.alu_result,
                      write_data: ex_if.write_data,
                      rd:         ex_if.rd,
                      pc_plus4:   ex_if.pc_plus4};

    // Ready depends only on the skid flop, never on downstream ready.
    assign ex_if.ready = ~s_vld_q;
    assign acc         = ex_if.valid & ~s_vld_q;
    assign take        = m_vld_q & mem_if.ready;

    always_comb begin
        m_d     = m_q;
        s_d     = s_q;
        m_vld_d = m_vld_q;
        s_vld_d = s_vld_q;
        if (i_flush) begin
            // Payload is left in place; only the valid bits are dropped.
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (s_vld_q && take) begin
            // Skid refills main; acc cannot occur since ready is low.
            m_d     = s_q;
            s_vld_d = 1'b0;
        end else if (acc && (!m_vld_q || take)) begin
            m_d     = in_ent;
            m_vld_d = 1'b1;
        end else if (acc) begin
            s_d     = in_ent;
            s_vld_d = 1'b1;
        end else if (take) begin
            m_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            m_q     <= '0;
            s_q     <= '0;
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
        end else begin
            m_q     <= m_d;
            s_q     <= s_d;
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
        end
    end

    // Writes to x0 never reach the register file or the forwarding network.
    assign rw_gated          = m_vld_q & m_q.reg_write & (m_q.rd != '0);
    assign mem_if.valid      = m_vld_q;
    assign mem_if.reg_write  = rw_gated;
    assign mem_if.mem_write  = m_vld_q & m_q.mem_write;
    assign mem_if.result_src = m_q.result_src;
    assign mem_if.alu_result = m_q.alu_result;
    assign mem_if.write_data = m_q.write_data;
    assign mem_if.rd         = m_q.rd;
    assign mem_if.pc_plus4   = m_q.pc_plus4;
    assign o_fwd_en          = rw_gated;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (m_vld_q && !mem_if.ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (!m_vld_q && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt  = stall_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`else
    assign o_stall_cnt  = '0;
    assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_mem_stage.sv
module tb_pipeline_mem_stage;
    localparam int XLEN  = 32;
    localparam int RS_W  = 2;
    localparam int RD_W  = 5;
    localparam int CNT_W = 32;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             fwd_en;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    always #5 clk = ~clk;

    pipeline_mem_stage_if #(.XLEN(XLEN), .RS_W(RS_W), .RD_W(RD_W)) ex_bus ();
    pipeline_mem_stage_if #(.XLEN(XLEN), .RS_W(RS_W), .RD_W(RD_W)) mem_bus ();

    pipeline_mem_stage #(.XLEN(XLEN), .RS_W(RS_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .ex_if        (ex_bus.slave),
        .mem_if       (mem_bus.master),
        .o_fwd_en     (fwd_en),
        .o_stall_cnt  (stall_cnt),
        .o_bubble_cnt (bubble_cnt)
    );

    // Reference model: a FIFO of at most two entries plus the last shown payload.
    ent_t    mq[$];
    ent_t    m_pay;
    longint  stall_m;
    longint  bubble_m;
    int      errors = 0;
    int      checks = 0;
    bit      last_acc;
    ent_t    zero_ent;
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit ev, er, erw, emw;
        ev  = (mq.size() > 0);
        er  = (mq.size() < 2);
        erw = ev & m_pay.rw & (m_pay.rd != 5'd0);
        emw = ev & m_pay.mw;
        chk("o_valid",      64'(mem_bus.valid),      64'(ev));
        chk("o_ready",      64'(ex_bus.ready),       64'(er));
        chk("o_reg_write",  64'(mem_bus.reg_write),  64'(erw));
        chk("o_mem_write",  64'(mem_bus.mem_write),  64'(emw));
        chk("o_fwd_en",     64'(fwd_en),             64'(erw));
        chk("o_result_src", 64'(mem_bus.result_src), 64'(m_pay.rs));
        chk("o_alu_result", 64'(mem_bus.alu_result), 64'(m_pay.alu));
        chk("o_write_data", 64'(mem_bus.write_data), 64'(m_pay.wd));
        chk("o_rd",         64'(mem_bus.rd),         64'(m_pay.rd));
        chk("o_pc_plus4",   64'(mem_bus.pc_plus4),   64'(m_pay.pc));
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk("o_stall_cnt",  64'(stall_cnt),          64'(stall_m));
        chk("o_bubble_cnt", 64'(bubble_cnt),         64'(bubble_m));
`else
        chk("o_stall_cnt",  64'(stall_cnt),          64'd0);
        chk("o_bubble_cnt", 64'(bubble_cnt),         64'd0);
`endif
    endtask

    // One cycle: check current outputs, apply inputs, advance model and DUT.
    task automatic step(bit v, ent_t e, bit rdy, bit fl, bit rs);
        bit cur_v, cur_r;
        check_all();
        rst                  = rs;
        flush                = fl;
        ex_bus.valid         = v;
        ex_bus.reg_write     = e.rw;
        ex_bus.result_src    = e.rs;
        ex_bus.mem_write     = e.mw;
        ex_bus.alu_result    = e.alu;
        ex_bus.write_data    = e.wd;
        ex_bus.rd            = e.rd;
        ex_bus.pc_plus4      = e.pc;
        mem_bus.ready        = rdy;
        cur_v    = (mq.size() > 0);
        cur_r    = (mq.size() < 2);
        last_acc = v & cur_r & ~fl & ~rs;
        if (rs) begin
            stall_m  = 0;
            bubble_m = 0;
            mq.delete();
            m_pay = zero_ent;
        end else begin
            if (cur_v && !rdy && stall_m < CNT_MAX) stall_m++;
            if (!cur_v && bubble_m < CNT_MAX) bubble_m++;
            if (fl) begin
                mq.delete();
            end else begin
                if (cur_v && rdy) void'(mq.pop_front());
                if (last_acc) mq.push_back(e);
                if (mq.size() > 0) m_pay = mq[0];
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic ent_t rnd_ent(logic [31:0] alu);
        ent_t e;
        e.rw  = 1'($urandom_range(0, 1));
        e.rs  = 2'($urandom_range(0, 3));
        e.mw  = 1'($urandom_range(0, 1));
        e.alu = alu;
        e.wd  = $urandom;
        e.rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        e.pc  = $urandom;
        return e;
    endfunction

    initial begin
        ent_t e, c;
        int   n;
        zero_ent = '{rw: 1'b0, rs: 2'd0, mw: 1'b0, alu: 32'd0, wd: 32'd0, rd: 5'd0, pc: 32'd0};
        rst = 1'b1; flush = 1'b0; mem_bus.ready = 1'b1;
        ex_bus.valid = 1'b0; ex_bus.reg_write = 1'b0; ex_bus.result_src = '0;
        ex_bus.mem_write = 1'b0; ex_bus.alu_result = '0; ex_bus.write_data = '0;
        ex_bus.rd = '0; ex_bus.pc_plus4 = '0;
        mq.delete(); m_pay = zero_ent; stall_m = 0; bubble_m = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset state.
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b1);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b1);

        // Streaming: 8 back-to-back entries with ready held high.
        for (int i = 0; i < 8; i++) step(1'b1, rnd_ent(32'h100 + 32'(i)), 1'b1, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);

        // Back-pressure: 0xA, 0xB fill both slots, 0xC held until accepted.
        step(1'b1, rnd_ent(32'hA), 1'b0, 1'b0, 1'b0);
        step(1'b1, rnd_ent(32'hB), 1'b0, 1'b0, 1'b0);
        c = rnd_ent(32'hC);
        for (int i = 0; i < 3; i++) step(1'b1, c, 1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            step(1'b1, c, 1'b1, 1'b0, 1'b0);
            n++;
        end while (!last_acc && n < 10);
        checks++;
        if (!last_acc) begin
            errors++;
            $error("FAIL bp_accept_c observed=0 expected=1");
        end
        for (int i = 0; i < 4; i++) step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);

        // Flush with both slots full and a new entry offered in the same cycle.
        e = rnd_ent(32'h200); e.mw = 1'b1;
        step(1'b1, e, 1'b0, 1'b0, 1'b0);
        e = rnd_ent(32'h201); e.mw = 1'b1;
        step(1'b1, e, 1'b0, 1'b0, 1'b0);
        e = rnd_ent(32'h202); e.mw = 1'b1;
        step(1'b1, e, 1'b0, 1'b1, 1'b0);
        step(1'b0, zero_ent, 1'b0, 1'b0, 1'b0);

        // Rd gating: rd=0 then rd=5 with reg_write set.
        e = rnd_ent(32'h300); e.rw = 1'b1; e.rd = 5'd0;
        step(1'b1, e, 1'b1, 1'b0, 1'b0);
        e.rd = 5'd5;
        step(1'b1, e, 1'b1, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);

        // Reset while skid holds an entry, then one entry after release.
        step(1'b1, rnd_ent(32'h400), 1'b0, 1'b0, 1'b0);
        step(1'b1, rnd_ent(32'h401), 1'b0, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b0, 1'b0, 1'b1);
        step(1'b1, rnd_ent(32'h402), 1'b1, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);

        // Counters: 3 stall cycles, 2 empty cycles, then a flush.
        step(1'b1, rnd_ent(32'h500), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, zero_ent, 1'b0, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);
        step(1'b1, rnd_ent(32'h501), 1'b0, 1'b0, 1'b0);
        step(1'b0, zero_ent, 1'b0, 1'b1, 1'b0);
        step(1'b0, zero_ent, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), rnd_ent($urandom), 1'($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 79) == 0));
        end
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_mem_stage.md
Name: pipeline_mem_stage

Overview:
Parametrised EX->MEM pipeline stage register for the RV32I multicycle/pipelined core, with a valid/ready handshake in place of free-running latches. A two-entry (main + skid) buffer sustains full throughput when MEM back-pressures. The stage supports synchronous flush, bubble gating of side-effecting controls, and a registered forwarding tap for the hazard unit.

Parameters:
XLEN, 32, width of ALU result, store data and PC+4
RS_W, 2, width of ResultSrc select
RD_W, 5, destination register index width
CNT_W, 32, width of optional performance counters

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_flush  in  1  synchronous kill of all held and incoming entries
i_valid  in  1  EX presents a valid entry
o_ready  out  1  stage can accept this cycle
i_reg_write  in  1  RegWriteE
i_result_src  in  RS_W  ResultSrcE
i_mem_write  in  1  MemWriteE
i_alu_result  in  XLEN  ALUResultE
i_write_data  in  XLEN  WriteDataE
i_rd  in  RD_W  RdE
i_pc_plus4  in  XLEN  PCPlus4E
o_valid  out  1  MEM entry valid
i_ready  in  1  MEM consumes entry this cycle
o_reg_write  out  1  RegWriteM, gated
o_result_src  out  RS_W  ResultSrcM
o_mem_write  out  1  MemWriteM, gated
o_alu_result  out  XLEN  ALUResultM
o_write_data  out  XLEN  WriteDataM
o_rd  out  RD_W  RdM
o_pc_plus4  out  XLEN  PCPlus4M
o_fwd_en  out  1  forwarding tap valid: o_valid & o_reg_write
o_stall_cnt  out  CNT_W  optional counter
o_bubble_cnt  out  CNT_W  optional counter

Behaviour:
- Storage: main slot M (drives outputs) and skid slot S, each holding all payload fields plus a valid bit.
- Events: acc = i_valid & o_ready; take = o_valid & i_ready.
- o_ready = ~S.valid. This is a registered term, with no combinational path from i_ready.
- Update priority:
  1. i_rst.
  2. i_flush.
  3. Normal operation.
- Normal operation rules:
  - S.valid & take: M <= S, S.valid <= 0. No accept is possible this cycle.
  - acc & (~M.valid | take): M <= input.
  - acc & M.valid & ~take: S <= input, so o_ready drops next cycle.
  - take & no refill: M.valid <= 0.
  - Otherwise M and S hold.
- Latency: 1 cycle from acc to o_valid when M is free. Throughput is 1 entry/cycle while i_ready=1.
- Ordering: strictly FIFO. An entry in S always leaves after the entry in M.
- Flush: M.valid and S.valid are cleared next cycle, and any acc in the same cycle is discarded. Payload fields hold their values. The flush is effective even with i_ready=0.
- Gating (combinational on M):
  - o_reg_write = M.valid & M.reg_write & (M.rd != 0).
  - o_mem_write = M.valid & M.mem_write.
  - Other payload outputs show M contents regardless of valid.
- Reset: all valid bits, payload fields and counters go to 0. Resulting output values: o_valid=0, o_ready=1, every payload output 0, o_fwd_en=0.
- Reset mid-operation drops both entries with no partial writes. The first acc after reset is serviced normally.
- Full condition: M and S both valid gives o_ready=0. i_valid is ignored, and EX must hold its payload.
- Empty condition: o_valid=0, and i_ready is don't-care.

Optional Feature:
PIPE_STAGE_PERF_CNT_EN
- Defined:
  - o_stall_cnt increments on each cycle with o_valid & ~i_ready.
  - o_bubble_cnt increments on each cycle with ~o_valid.
  - Both saturate at all-ones.
  - Both are cleared by i_rst only, not by i_flush.
- Undefined: both outputs are tied to 0, and no counter flops are inferred.

Test Plan:
- Streaming: i_ready=1, 8 back-to-back entries with alu_result=0x100..0x107 -> each appears one cycle after its acc, o_ready stays 1, no gaps.
- Back-pressure: hold i_ready=0 while sending 0xA, then 0xB; 0xC is offered but must not be accepted -> o_ready=0 after 0xB; release i_ready -> outputs 0xA, 0xB, 0xC in order, none lost or duplicated.
- Flush with M and S full (i_valid=1 in the same cycle) -> next cycle o_valid=0, o_ready=1, o_mem_write=0, incoming entry absent.
- Rd gating: reg_write=1, rd=0 -> o_reg_write=0, o_fwd_en=0; the same entry with rd=5 -> o_reg_write=1, o_fwd_en=1.
- Reset asserted while S holds an entry -> next cycle all outputs 0, o_ready=1; the first entry after release passes with 1-cycle latency.
- With PIPE_STAGE_PERF_CNT_EN: 3 stall cycles, then 2 empty cycles -> o_stall_cnt=3, o_bubble_cnt=2 plus reset-idle cycles. Both are unchanged by a flush.
